// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port 32-bit RAM. Instruction fetch and
// data requests share the RAM. Grants are combinational. Ties are broken by a
// 1-bit round-robin pointer. Read data is routed back using an owner tag
// registered at grant time.
module mem_arbiter #(
  parameter int unsigned RAM_AW = 14
) (
  input  logic              clk,
  input  logic              reset,
  // Instruction fetch port (read only)
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  // Data port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  // RAM command port
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic [1:0] {OwnNone, OwnIf, OwnD} owner_e;

  // last_q: 0 = fetch granted most recently, 1 = data granted most recently
  logic   last_q, last_d;
  owner_e owner_q, owner_d;

  // Byte-offset and above-RAM address bits are intentionally dropped (wrap-around).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:RAM_AW+2], if_addr[1:0],
                              d_addr[31:RAM_AW+2], d_addr[1:0]};

  // Arbitration, pointer/owner next state and RAM command
  always_comb begin
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    last_d    = last_q;
    owner_d   = OwnNone;
    ram_en    = 1'b0;
    ram_we    = 4'b0000;
    ram_addr  = if_addr[RAM_AW+1:2];
    ram_wdata = d_wdata;

    if (!reset) begin
      if (if_req && d_req) begin
        // Grant whichever side was not served most recently
        if (last_q) begin
          if_gnt = 1'b1;
        end else begin
          d_gnt = 1'b1;
        end
      end else begin
        if_gnt = if_req;
        d_gnt  = d_req;
      end
    end

    if (if_gnt) begin
      last_d   = 1'b0;
      owner_d  = OwnIf;
      ram_en   = 1'b1;
      ram_addr = if_addr[RAM_AW+1:2];
    end else if (d_gnt) begin
      last_d   = 1'b1;
      // Writes produce no response, so only reads claim the return path
      owner_d  = d_we ? OwnNone : OwnD;
      ram_en   = 1'b1;
      ram_we   = d_we ? d_be : 4'b0000;
      ram_addr = d_addr[RAM_AW+1:2];
    end
  end

  // Response routing; gated by reset so a read granted just before reset is dropped
  always_comb begin
    if_rvalid = (owner_q == OwnIf) && !reset;
    d_rvalid  = (owner_q == OwnD) && !reset;
    if_rdata  = if_rvalid ? ram_rdata : 32'h0;
    d_rdata   = d_rvalid ? ram_rdata : 32'h0;
  end

  // Round-robin pointer and owner tag registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q  <= 1'b0;
      owner_q <= OwnNone;
    end else begin
      last_q  <= last_d;
      owner_q <= owner_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural 16K x 32 RAM.
module tb_mem_arbiter;

  localparam int unsigned RAM_AW = 14;

  logic              clk = 1'b0;
  logic              reset;
  logic              if_req;
  logic [31:0]       if_addr;
  logic              if_gnt, if_rvalid;
  logic [31:0]       if_rdata;
  logic              d_req, d_we;
  logic [3:0]        d_be;
  logic [31:0]       d_addr, d_wdata;
  logic              d_gnt, d_rvalid;
  logic [31:0]       d_rdata;
  logic              ram_en;
  logic [3:0]        ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata = 32'h0;

  int n_checks = 0;
  int n_errors = 0;

  mem_arbiter #(.RAM_AW(RAM_AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_be      (d_be),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM model: word i preloaded with 0xA500_0000 | i
  logic [31:0] mem [0:(1<<RAM_AW)-1];

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (ram_en) begin
      if (|ram_we) mem[ram_addr] <= merge(mem[ram_addr], ram_wdata, ram_we);
      ram_rdata <= mem[ram_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply one cycle of stimulus just after the falling edge, then settle
  task automatic drive(input logic rst, input logic ireq, input logic [31:0] iaddr,
                       input logic dreq, input logic dwe, input logic [3:0] dbe,
                       input logic [31:0] daddr, input logic [31:0] dwdata);
    @(negedge clk);
    reset   = rst;
    if_req  = ireq;
    if_addr = iaddr;
    d_req   = dreq;
    d_we    = dwe;
    d_be    = dbe;
    d_addr  = daddr;
    d_wdata = dwdata;
    #1;
  endtask

  task automatic exp_resp(input string tag, input logic ig, input logic dg,
                          input logic iv, input logic [31:0] ird,
                          input logic dv, input logic [31:0] drd);
    check({tag, ".if_gnt"},    {31'b0, if_gnt},    {31'b0, ig});
    check({tag, ".d_gnt"},     {31'b0, d_gnt},     {31'b0, dg});
    check({tag, ".if_rvalid"}, {31'b0, if_rvalid}, {31'b0, iv});
    check({tag, ".if_rdata"},  if_rdata,           ird);
    check({tag, ".d_rvalid"},  {31'b0, d_rvalid},  {31'b0, dv});
    check({tag, ".d_rdata"},   d_rdata,            drd);
  endtask

  task automatic exp_ram(input string tag, input logic en, input logic [3:0] we,
                         input logic [31:0] addr);
    check({tag, ".ram_en"}, {31'b0, ram_en}, {31'b0, en});
    check({tag, ".ram_we"}, {28'b0, ram_we}, {28'b0, we});
    if (en) check({tag, ".ram_addr"}, 32'(ram_addr), addr);
  endtask

  initial begin
    for (int i = 0; i < (1 << RAM_AW); i++) mem[i] = 32'hA500_0000 | i;
    reset = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0;
    d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;

    // Reset held with both requesting: nothing may be granted
    drive(1, 1, 32'h4, 1, 0, 4'h0, 32'h8, 32'h0);
    exp_resp("rst0", 0, 0, 0, 32'h0, 0, 32'h0);
    exp_ram("rst0", 0, 4'h0, 32'h0);
    drive(1, 1, 32'h4, 1, 0, 4'h0, 32'h8, 32'h0);
    exp_resp("rst1", 0, 0, 0, 32'h0, 0, 32'h0);

    // Tie after reset: data first, then alternate
    drive(0, 1, 32'h4, 1, 0, 4'h0, 32'h8, 32'h0);
    exp_resp("tie0", 0, 1, 0, 32'h0, 0, 32'h0);
    exp_ram("tie0", 1, 4'h0, 32'h2);
    drive(0, 1, 32'h4, 1, 0, 4'h0, 32'h8, 32'h0);
    exp_resp("tie1", 1, 0, 0, 32'h0, 1, 32'hA500_0002);
    exp_ram("tie1", 1, 4'h0, 32'h1);
    drive(0, 1, 32'h4, 1, 0, 4'h0, 32'h8, 32'h0);
    exp_resp("tie2", 0, 1, 1, 32'hA500_0001, 0, 32'h0);
    drive(0, 1, 32'h4, 1, 0, 4'h0, 32'h8, 32'h0);
    exp_resp("tie3", 1, 0, 0, 32'h0, 1, 32'hA500_0002);

    // Fetch only
    drive(0, 1, 32'h10, 0, 0, 4'h0, 32'h0, 32'h0);
    exp_resp("fetch", 1, 0, 1, 32'hA500_0001, 0, 32'h0);
    exp_ram("fetch", 1, 4'h0, 32'h4);

    // Partial data write
    drive(0, 0, 32'h0, 1, 1, 4'b0011, 32'h40, 32'hDEAD_BEEF);
    exp_resp("wr", 0, 1, 1, 32'hA500_0004, 0, 32'h0);
    exp_ram("wr", 1, 4'b0011, 32'h10);
    check("wr.ram_wdata", ram_wdata, 32'hDEAD_BEEF);

    // Readback of the written word; the write must not produce d_rvalid
    drive(0, 0, 32'h0, 1, 0, 4'h0, 32'h40, 32'h0);
    exp_resp("rd40", 0, 1, 0, 32'h0, 0, 32'h0);
    exp_ram("rd40", 1, 4'h0, 32'h10);

    // Write with no byte enables still takes a grant cycle
    drive(0, 0, 32'h0, 1, 1, 4'b0000, 32'h44, 32'hFFFF_FFFF);
    exp_resp("be0", 0, 1, 0, 32'h0, 1, 32'hA500_BEEF);
    exp_ram("be0", 1, 4'h0, 32'h11);
    drive(0, 0, 32'h0, 1, 0, 4'h0, 32'h44, 32'h0);
    exp_resp("rd44", 0, 1, 0, 32'h0, 0, 32'h0);

    // Address wrap-around
    drive(0, 1, 32'h0001_0004, 0, 0, 4'h0, 32'h0, 32'h0);
    exp_resp("wrap", 1, 0, 0, 32'h0, 1, 32'hA500_0011);
    exp_ram("wrap", 1, 4'h0, 32'h1);

    // Back-to-back: fetch at N, data read at N+1
    drive(0, 1, 32'h20, 0, 0, 4'h0, 32'h0, 32'h0);
    exp_resp("b2b0", 1, 0, 1, 32'hA500_0001, 0, 32'h0);
    exp_ram("b2b0", 1, 4'h0, 32'h8);
    drive(0, 0, 32'h0, 1, 0, 4'h0, 32'h24, 32'h0);
    exp_resp("b2b1", 0, 1, 1, 32'hA500_0008, 0, 32'h0);
    exp_ram("b2b1", 1, 4'h0, 32'h9);
    drive(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    exp_resp("b2b2", 0, 0, 0, 32'h0, 1, 32'hA500_0009);
    exp_ram("b2b2", 0, 4'h0, 32'h0);

    // Data granted most recently, pointer kept through idle: fetch wins the tie
    drive(0, 1, 32'hC, 1, 0, 4'h0, 32'h8, 32'h0);
    exp_resp("tie_rr", 1, 0, 0, 32'h0, 0, 32'h0);
    exp_ram("tie_rr", 1, 4'h0, 32'h3);

    // Reset right after a read grant: no rvalid, everything quiet
    drive(1, 1, 32'hC, 1, 0, 4'h0, 32'h8, 32'h0);
    exp_resp("rstrd0", 0, 0, 0, 32'h0, 0, 32'h0);
    exp_ram("rstrd0", 0, 4'h0, 32'h0);
    drive(1, 1, 32'hC, 1, 0, 4'h0, 32'h8, 32'h0);
    exp_resp("rstrd1", 0, 0, 0, 32'h0, 0, 32'h0);

    // First cycle out of reset grants immediately; data wins the tie again
    drive(0, 1, 32'hC, 1, 0, 4'h0, 32'h8, 32'h0);
    exp_resp("rel0", 0, 1, 0, 32'h0, 0, 32'h0);
    exp_ram("rel0", 1, 4'h0, 32'h2);
    drive(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    exp_resp("rel1", 0, 0, 0, 32'h0, 1, 32'hA500_0002);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter RAM_AW, default 14, word-address width of the shared RAM (16K x 32-bit words).
REQ-002 Port clk  input  1  system clock; all logic on rising edge.
REQ-003 Port reset  input  1  synchronous, active-high reset.
REQ-004 Ports if_req in 1, if_addr in 32: instruction-fetch read request and byte address.
REQ-005 Ports if_gnt out 1, if_rvalid out 1, if_rdata out 32: fetch grant, read-data valid, read data.
REQ-006 Ports d_req in 1, d_we in 1, d_be in 4, d_addr in 32, d_wdata in 32: data request, write enable, byte enables, byte address, write data.
REQ-007 Ports d_gnt out 1, d_rvalid out 1, d_rdata out 32: data grant, read-data valid, read data.
REQ-008 Ports ram_en out 1, ram_we out 4, ram_addr out RAM_AW, ram_wdata out 32: single-port RAM command.
REQ-009 Port ram_rdata in 32: RAM read data, valid exactly 1 cycle after a read command.

Function
REQ-010 At most one of if_gnt, d_gnt SHALL be high in any cycle.
REQ-011 Grant is combinational: requester granted in cycle N has its command on the RAM port in cycle N.
REQ-012 Requester SHALL hold req and its address/data stable until it sees gnt; the arbiter SHALL NOT depend on early deassertion.
REQ-013 One request → one grant cycle; a requester holding req after its grant is a new request.
REQ-014 Arbitration: only one requesting → grant it; both requesting → grant the one not granted most recently (1-bit round-robin pointer `last`).
REQ-015 `last` updates on every grant cycle to the granted requester; unchanged in idle cycles.
REQ-016 Granted cycle: ram_en=1, ram_addr = addr[RAM_AW+1:2]; upper address bits and addr[1:0] ignored (wrap-around).
REQ-017 Fetch grant: ram_we=4'b0000.
REQ-018 Data grant: ram_we = d_we ? d_be : 4'b0000; ram_wdata = d_wdata.
REQ-019 No grant: ram_en=0, ram_we=0; ram_addr/ram_wdata don't-care.
REQ-020 Read latency: read granted in cycle N → owner's rvalid high for exactly cycle N+1, rdata = ram_rdata in that cycle.
REQ-021 Response routing SHALL use a registered owner tag (none/if/d) captured at grant, independent of cycle-N+1 requests.
REQ-022 Data writes SHALL NOT assert d_rvalid; a write with d_be=0 still consumes a grant cycle, RAM contents unchanged.
REQ-023 Back-to-back: a new grant allowed in cycle N+1 while the cycle-N response returns; full throughput 1 access/cycle.
REQ-024 Non-owner rdata SHALL be 0 when its rvalid is low.

Reset
REQ-025 While reset=1: if_gnt, d_gnt, if_rvalid, d_rvalid, ram_en = 0; ram_we = 0; rdata outputs = 0.
REQ-026 Reset sets `last` to fetch (data wins the first tie) and the owner tag to none.
REQ-027 Read granted in the cycle before reset asserts SHALL produce no rvalid.
REQ-028 First grant possible in the first cycle with reset=0.

Verification
REQ-029 Fetch only: if_req=1, if_addr=0x0000_0010 → if_gnt same cycle, ram_addr=4, ram_we=0; next cycle if_rvalid=1, if_rdata=ram_rdata.
REQ-030 Tie after reset: both req in first cycle → d_gnt first, if_gnt next cycle, then alternating d/if/d while both held.
REQ-031 Data write: d_we=1, d_be=4'b0011, d_addr=0x40, d_wdata=0xDEADBEEF → ram_we=0011, ram_addr=0x10; no d_rvalid; readback returns 0x0000BEEF in low half with old upper half.
REQ-032 Wrap: if_addr=0x0001_0004 with RAM_AW=14 → ram_addr=1.
REQ-033 Back-to-back: fetch at N, data read at N+1 → if_rvalid at N+1, d_rvalid at N+2, never both in the same cycle, each with correct data.
REQ-034 Reset mid-read: grant read at N, reset=1 at N+1 → no rvalid at N+1; all outputs 0 while reset held.
